// File: rtl/led_sequencer.sv
// led_sequencer: steps a per-channel LED mask through NUM_STEPS steps with PWM dimming.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset
//   button   - start request, rising edge starts a sequence from IDLE
//   stop     - level abort, wins over everything else
//   loop_en  - 1 repeats the sequence, 0 runs it once
//   pattern  - channel mask per step, step s at [s*NUM_CH +: NUM_CH]
//   duty     - PWM brightness, 0 = off, all-ones = fully on
//   led      - registered channel drive, lags state by one cycle
//   busy     - high while running
//   step_idx - current step index
//   done     - one-cycle pulse when a one-shot sequence completes
module led_sequencer #(
    parameter int NUM_CH    = 3,
    parameter int NUM_STEPS = 3,
    parameter int DWELL_MAX = 10,
    parameter int PWM_WIDTH = 4,
    localparam int SW = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1,
    localparam int DW = DWELL_MAX > 1 ? $clog2(DWELL_MAX) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        button,
    input  logic                        stop,
    input  logic                        loop_en,
    input  logic [NUM_STEPS*NUM_CH-1:0] pattern,
    input  logic [PWM_WIDTH-1:0]        duty,
    output logic [NUM_CH-1:0]           led,
    output logic                        busy,
    output logic [SW-1:0]               step_idx,
    output logic                        done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [SW-1:0]        step, step_n;
    logic [DW-1:0]        dwell, dwell_n;
    logic [PWM_WIDTH-1:0] pwm_cnt, pwm_n;
    logic                 done_n, button_q, start, pwm_on, step_end, seq_end;

    assign start    = button & ~button_q;
    assign step_end = dwell == DW'(DWELL_MAX - 1);
    assign seq_end  = step_end && step == SW'(NUM_STEPS - 1);
    assign pwm_on   = (duty == '1) | (pwm_cnt < duty);
    assign busy     = state == RUN;
    assign step_idx = step;

    always_comb begin
        state_n = state;
        step_n  = step;
        dwell_n = dwell;
        pwm_n   = '0;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start && !stop) begin
                state_n = RUN;
                step_n  = '0;
                dwell_n = '0;
            end
        end else if (stop) begin
            state_n = IDLE;
        end else begin
            pwm_n   = pwm_cnt + PWM_WIDTH'(1);
            dwell_n = step_end ? '0 : dwell + DW'(1);
            if (seq_end) begin
                step_n  = '0;
                state_n = loop_en ? RUN : IDLE;
                done_n  = !loop_en;
                // one-shot exit keeps the last step visible on step_idx
                if (!loop_en) step_n = step;
            end else if (step_end) begin
                step_n = step + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            dwell    <= '0;
            pwm_cnt  <= '0;
            done     <= 1'b0;
            led      <= '0;
            // held high so a button already pressed at reset release is not a start
            button_q <= 1'b1;
        end else begin
            state    <= state_n;
            step     <= step_n;
            dwell    <= dwell_n;
            pwm_cnt  <= pwm_n;
            done     <= done_n;
            led      <= state == RUN ? pattern[int'(step)*NUM_CH +: NUM_CH] & {NUM_CH{pwm_on}} : '0;
            button_q <= button;
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer.
module tb_led_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [8:0] pattern = 9'b100_010_001;
    logic [3:0] duty = 4'd15;
    logic [2:0] led;
    logic       busy;
    logic [1:0] step_idx;
    logic       done;
    int         checks = 0;
    int         errors = 0;
    int         cnt;

    led_sequencer dut (
        .clk(clk), .reset(reset), .button(button), .stop(stop), .loop_en(loop_en),
        .pattern(pattern), .duty(duty), .led(led), .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_seq;
        button = 1'b1;
        tick();
        button = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_led", 32'(led), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_step", 32'(step_idx), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        start_seq();
        check("os_busy0", 32'(busy), 1);
        check("os_led0", 32'(led), 0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            check($sformatf("os_led_%0d", k), 32'(led), k <= 10 ? 1 : k <= 20 ? 2 : k <= 30 ? 4 : 0);
            check($sformatf("os_busy_%0d", k), 32'(busy), k <= 29 ? 1 : 0);
            check($sformatf("os_done_%0d", k), 32'(done), k == 30 ? 1 : 0);
            if (k == 15) check("os_step_15", 32'(step_idx), 1);
            if (k == 25) check("os_step_25", 32'(step_idx), 2);
        end

        loop_en = 1'b1;
        start_seq();
        for (int k = 1; k <= 31; k++) begin
            tick();
            check($sformatf("lp_busy_%0d", k), 32'(busy), 1);
            check($sformatf("lp_done_%0d", k), 32'(done), 0);
            if (k == 30) check("lp_led_30", 32'(led), 4);
            if (k == 31) check("lp_led_31", 32'(led), 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("lp_stop_busy", 32'(busy), 0);
        check("lp_stop_done", 32'(done), 0);
        tick();

        loop_en = 1'b0;
        start_seq();
        repeat (14) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_done", 32'(done), 0);
        check("ab_step", 32'(step_idx), 1);
        check("ab_led15", 32'(led), 2);
        tick();
        check("ab_led16", 32'(led), 0);
        check("ab_step16", 32'(step_idx), 1);
        check("ab_done16", 32'(done), 0);

        duty = 4'd4;
        loop_en = 1'b1;
        start_seq();
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (led != 0) cnt++;
            if (k == 1) check("pwm_on_1", 32'(led), 1);
            if (k == 5) check("pwm_off_5", 32'(led), 0);
        end
        check("pwm_on_count", 32'(cnt), 4);
        duty = 4'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pwm0_led", 32'(led), 0);
            check("pwm0_busy", 32'(busy), 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        duty = 4'd15;
        loop_en = 1'b0;
        tick();

        reset = 1'b1;
        button = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("held_nostart", 32'(busy), 0);
        end
        button = 1'b0;
        tick();
        button = 1'b1;
        tick();
        check("held_start", 32'(busy), 1);
        repeat (5) tick();
        button = 1'b0;
        tick();
        button = 1'b1;
        tick();
        cnt = 0;
        for (int k = 8; k <= 35; k++) begin
            tick();
            if (done) cnt++;
            if (k == 12) check("held_step12", 32'(step_idx), 1);
            if (k == 29) check("held_busy29", 32'(busy), 1);
        end
        check("held_done_cnt", 32'(cnt), 1);
        check("held_busy_end", 32'(busy), 0);
        button = 1'b0;
        tick();

        button = 1'b1;
        stop = 1'b1;
        tick();
        check("sim_busy", 32'(busy), 0);
        button = 1'b0;
        stop = 1'b0;
        tick();
        check("sim_busy2", 32'(busy), 0);

        start_seq();
        repeat (12) tick();
        check("mid_step", 32'(step_idx), 1);
        check("mid_led", 32'(led), 2);
        reset = 1'b1;
        #1;
        check("mid_rst_led", 32'(led), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_step", 32'(step_idx), 0);
        tick();
        check("mid_rst_done2", 32'(done), 0);
        reset = 1'b0;
        tick();
        check("mid_after_busy", 32'(busy), 0);
        check("mid_after_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
